// File: rtl/des_key_schedule.sv
// des_key_schedule: DES round-key generator, one PC-2 subkey per valid/ready handshake.
// Optional macro DES_DECRYPT_EN adds i_decrypt and reverse (K16..K1) emission order.
`default_nettype none

module des_key_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [55:0] i_key_in,
   input  logic        i_key_valid,
   output logic        o_key_ready,
`ifdef DES_DECRYPT_EN
   input  logic        i_decrypt,
`endif
   output logic [47:0] o_subkey,
   output logic        o_subkey_valid,
   input  logic        i_subkey_ready,
   output logic [3:0]  o_round_idx,
   output logic        o_last
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

   // PC-2: entry i gives the 1-based C||D bit feeding subkey bit 47-i.
   localparam logic [0:47][5:0] c_PC2 = {
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
      6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
      6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
      6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
      6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

   state_t      r_state, w_state_nxt;
   logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
   logic [47:0] r_subkey;
   logic [3:0]  r_round_idx;
   logic        r_last;
   logic        w_accept, w_advance, w_final;
   logic [4:0]  w_j_enc;
`ifdef DES_DECRYPT_EN
   logic        r_dec;
   logic [4:0]  w_j_dec;
`endif

   // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
   function automatic logic f_shift1(input logic [4:0] j);
      return (j == 5'd1) || (j == 5'd2) || (j == 5'd9) || (j == 5'd16);
   endfunction

   function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

`ifdef DES_DECRYPT_EN
   function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction
`endif

   function automatic logic [47:0] f_pc2(input logic [55:0] cd);
      logic [47:0] k;
      k = '0;
      for (int i = 0; i < 48; i++) begin
         k[47-i] = cd[56 - int'(c_PC2[i])];
      end
      return k;
   endfunction

   assign w_accept  = (r_state == S_IDLE) && i_key_valid;
   assign w_advance = (r_state == S_EMIT) && i_subkey_ready && (r_round_idx != 4'd15);
   assign w_final   = (r_state == S_EMIT) && i_subkey_ready && (r_round_idx == 4'd15);
   // Emission number of the subkey being prepared (current round_idx + 1, plus one).
   assign w_j_enc   = {1'b0, r_round_idx} + 5'd2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_key_valid) w_state_nxt = S_EMIT;
         S_EMIT:  if (w_final)     w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_c_nxt = r_c;
      w_d_nxt = r_d;
`ifdef DES_DECRYPT_EN
      // Decrypt walks the rotations backwards, starting from C16||D16 = C0||D0.
      w_j_dec = 5'd16 - {1'b0, r_round_idx};
      if (w_accept) begin
         if (i_decrypt) begin
            w_c_nxt = i_key_in[55:28];
            w_d_nxt = i_key_in[27:0];
         end else begin
            w_c_nxt = f_rotl(i_key_in[55:28], 1'b1);
            w_d_nxt = f_rotl(i_key_in[27:0], 1'b1);
         end
      end else if (r_dec) begin
         w_c_nxt = f_rotr(r_c, f_shift1(w_j_dec));
         w_d_nxt = f_rotr(r_d, f_shift1(w_j_dec));
      end else begin
         w_c_nxt = f_rotl(r_c, f_shift1(w_j_enc));
         w_d_nxt = f_rotl(r_d, f_shift1(w_j_enc));
      end
`else
      if (w_accept) begin
         w_c_nxt = f_rotl(i_key_in[55:28], 1'b1);
         w_d_nxt = f_rotl(i_key_in[27:0], 1'b1);
      end else begin
         w_c_nxt = f_rotl(r_c, f_shift1(w_j_enc));
         w_d_nxt = f_rotl(r_d, f_shift1(w_j_enc));
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c         <= '0;
         r_d         <= '0;
         r_subkey    <= '0;
         r_round_idx <= '0;
         r_last      <= 1'b0;
`ifdef DES_DECRYPT_EN
         r_dec       <= 1'b0;
`endif
      end else if (w_accept || w_advance) begin
         r_c         <= w_c_nxt;
         r_d         <= w_d_nxt;
         r_subkey    <= f_pc2({w_c_nxt, w_d_nxt});
         r_round_idx <= w_accept ? 4'd0 : r_round_idx + 4'd1;
         r_last      <= w_advance && (r_round_idx == 4'd14);
`ifdef DES_DECRYPT_EN
         if (w_accept) r_dec <= i_decrypt;
`endif
      end else if (w_final) begin
         r_round_idx <= '0;
         r_last      <= 1'b0;
      end
   end

   assign o_key_ready    = (r_state == S_IDLE);
   assign o_subkey_valid = (r_state == S_EMIT);
   assign o_subkey       = r_subkey;
   assign o_round_idx    = r_round_idx;
   assign o_last         = r_last;

endmodule

`default_nettype wire
